// File: rtl/alu_pkg.sv
// Shared encodings for the execute stage: internal ALU ops, instruction opcodes,
// R-type function codes and the control FSM state type.
package alu_pkg;

    typedef enum logic [2:0] {
        AluNone = 3'b000,
        AluAnd  = 3'b001,
        AluAdd  = 3'b010,
        AluSub  = 3'b011,
        AluSll  = 3'b100,
        AluSrl  = 3'b101,
        AluMul  = 3'b110
    } alu_op_e;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0010;
    localparam logic [3:0] OP_ADDI  = 4'b0011;
    localparam logic [3:0] OP_LW    = 4'b0100;
    localparam logic [3:0] OP_SW    = 4'b0101;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_BNE   = 4'b0111;

    localparam logic [2:0] FUNC_AND = 3'b000;
    localparam logic [2:0] FUNC_ADD = 3'b001;
    localparam logic [2:0] FUNC_SUB = 3'b010;
    localparam logic [2:0] FUNC_SLL = 3'b011;
    localparam logic [2:0] FUNC_SRL = 3'b100;
    localparam logic [2:0] FUNC_MUL = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDone
    } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode/func decode into an internal ALU op plus illegal and
// branch-type qualifiers.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [3:0] opcode_i,
    input  logic [2:0] func_i,
    output logic [2:0] alu_op_o,
    output logic       illegal_o,
    output logic       is_beq_o,
    output logic       is_bne_o
);

    always_comb begin
        alu_op_o  = AluNone;
        illegal_o = 1'b0;
        is_beq_o  = 1'b0;
        is_bne_o  = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                case (func_i)
                    FUNC_AND: alu_op_o = AluAnd;
                    FUNC_ADD: alu_op_o = AluAdd;
                    FUNC_SUB: alu_op_o = AluSub;
                    FUNC_SLL: alu_op_o = AluSll;
                    FUNC_SRL: alu_op_o = AluSrl;
                    FUNC_MUL: alu_op_o = AluMul;
                    default:  illegal_o = 1'b1;
                endcase
            end
            OP_ANDI:              alu_op_o = AluAnd;
            OP_ADDI, OP_LW, OP_SW: alu_op_o = AluAdd;
            OP_BEQ: begin
                alu_op_o = AluSub;
                is_beq_o = 1'b1;
            end
            OP_BNE: begin
                alu_op_o = AluSub;
                is_bne_o = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: decoded single-cycle ALU ops, an iterative shift-add multiply,
// status flags and branch resolution behind valid/ready handshakes.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       opcode_i,
    input  logic [2:0]       func_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             branch_taken_o,
    output logic             illegal_o
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam logic [SHW:0] MulSteps = (SHW + 1)'(WIDTH);

    state_e               state_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_step;
    logic [WIDTH-1:0]     mplier_q;
    logic [SHW:0]         cnt_q;
    logic [WIDTH-1:0]     result_q;
    logic                 zero_q;
    logic                 carry_q;
    logic                 overflow_q;
    logic                 branch_q;
    logic                 illegal_q;

    logic [2:0]           dec_op;
    logic                 dec_illegal;
    logic                 dec_beq;
    logic                 dec_bne;
    logic                 accept;

    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_zero;
    logic                 alu_carry;
    logic                 alu_ovf;
    logic                 alu_branch;

    alu_op_decode u_decode (
        .opcode_i  (opcode_i),
        .func_i    (func_i),
        .alu_op_o  (dec_op),
        .illegal_o (dec_illegal),
        .is_beq_o  (dec_beq),
        .is_bne_o  (dec_bne)
    );

    assign in_ready_o  = (state_q == StIdle) || ((state_q == StDone) && out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = (state_q == StDone);

    // Single-cycle datapath; illegal ops decode to AluNone and fall out as result 0.
    always_comb begin
        sum       = {1'b0, op_a_i} + {1'b0, op_b_i};
        diff      = {1'b0, op_a_i} - {1'b0, op_b_i};
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (dec_op)
            AluAnd: alu_res = op_a_i & op_b_i;
            AluAdd: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = (op_a_i[WIDTH-1] == op_b_i[WIDTH-1]) &&
                            (sum[WIDTH-1] != op_a_i[WIDTH-1]);
            end
            AluSub: begin
                alu_res   = diff[WIDTH-1:0];
                alu_carry = ~diff[WIDTH];
                alu_ovf   = (op_a_i[WIDTH-1] != op_b_i[WIDTH-1]) &&
                            (diff[WIDTH-1] != op_a_i[WIDTH-1]);
            end
            AluSll: alu_res = op_a_i << op_b_i[SHW-1:0];
            AluSrl: alu_res = op_a_i >> op_b_i[SHW-1:0];
            default: ;
        endcase
        alu_zero   = (alu_res == '0);
        alu_branch = (dec_beq && alu_zero) || (dec_bne && !alu_zero);
    end

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            mcand_q    <= '0;
            acc_q      <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            branch_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        if (dec_op == AluMul) begin
                            mcand_q  <= {{WIDTH{1'b0}}, op_a_i};
                            mplier_q <= op_b_i;
                            acc_q    <= '0;
                            cnt_q    <= MulSteps;
                            state_q  <= StMul;
                        end else begin
                            result_q   <= alu_res;
                            zero_q     <= alu_zero;
                            carry_q    <= alu_carry;
                            overflow_q <= alu_ovf;
                            branch_q   <= alu_branch;
                            illegal_q  <= dec_illegal;
                            state_q    <= StDone;
                        end
                    end else if ((state_q == StDone) && out_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                StMul: begin
                    acc_q    <= acc_step;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - 1'b1;
                    if (cnt_q == (SHW + 1)'(1)) begin
                        result_q   <= acc_step[WIDTH-1:0];
                        zero_q     <= (acc_step[WIDTH-1:0] == '0);
                        carry_q    <= |acc_step[2*WIDTH-1:WIDTH];
                        overflow_q <= 1'b0;
                        branch_q   <= 1'b0;
                        illegal_q  <= 1'b0;
                        state_q    <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign result_o       = result_q;
    assign zero_o         = zero_q;
    assign carry_o        = carry_q;
    assign overflow_o     = overflow_q;
    assign branch_taken_o = branch_q;
    assign illegal_o      = illegal_q;

endmodule
